cover_toggle_collector: RTL and testbench
=========================================

// Module: cover_toggle_collector
// PURPOSE
//  Synthesizable sink for per-bit toggle-cover events, for formal/FPGA builds where DPI is unavailable.
//  Records first hits of a WIDTH-bit cover group into a sticky bitmap.
//  Reports each newly covered point exactly once (until cleared) as a global cover index on a ready/valid stream.
//  Sits beside each toggle-cover group; its stream feeds the top-level coverage aggregator.
// PARAMETERS
//  WIDTH        65     cover points in this group
//  COVER_INDEX  0      global index of bit 0 of this group
//  COVER_TOTAL  8744   global cover-point count; elaboration error if COVER_INDEX+WIDTH > COVER_TOTAL
// PORTS
//  gbl_clk      in   1                 clock
//  reset        in   1                 synchronous, active-low
//  valid        in   WIDTH             per-bit cover events, sampled every edge
//  clr          in   1                 synchronous clear of all coverage state
//  evt_valid    out  1                 event present
//  evt_index    out  64                global cover index: COVER_INDEX + bit
//  evt_ready    in   1                 consumer accepts event
//  hit_count    out  $clog2(WIDTH+1)   distinct points hit since reset/clr
//  all_covered  out  1                 hit_count == WIDTH
//  rd_addr      in   $clog2(WIDTH)     bitmap read address
//  rd_hit       out  1                 hit[rd_addr], registered
// BEHAVIOUR
//  - Reset (reset==0 at edge): hit, pending, hit_count, rd_hit, evt_valid <= 0; evt_index <= 0; all_covered = 0. Inputs ignored.
//  - Per edge, when not in reset and clr==0:
//    - new = valid & ~hit
//    - hit <= hit | valid
//    - pending <= (pending & ~taken) | new
//    - hit_count <= hit_count + popcount(new), computed in full width; cannot overflow.
//  - Output register, 2 states:
//    - EMPTY: if pending!=0, load lowest set pending bit k (taken=1<<k),
//      evt_index<=COVER_INDEX+k, evt_valid<=1 -> HOLD.
//    - HOLD: evt_valid && !evt_ready: evt_index stable.
//      On evt_ready: load next lowest pending bit the same edge (back-to-back, 1 event/cycle);
//      if none, evt_valid<=0 -> EMPTY.
//  - Selection uses registered pending, so new hits are eligible next edge.
//  - Latency: bit first valid at edge t -> hit/pending set at t -> evt_valid at edge t+1 when EMPTY.
//  - A point already in hit, pending or the output register never generates a second event.
//  - clr==1: hit, pending, hit_count, evt_valid <= 0; valid sampled that edge is discarded.
//    clr overrides evt_valid stability (an un-accepted event is dropped).
//  - all_covered: combinational compare of registered hit_count.
//  - rd_hit <= hit[rd_addr] (1-cycle latency, pre-update bitmap); rd_addr >= WIDTH -> 0.
//  - evt_index arithmetic is 64-bit unsigned, matching the DPI longint cover index.
// STRUCTURE
//  - cover_pkg: COVER_TOTAL, cover_idx_t (64-bit), state enum {EMPTY, HOLD}.
//  - Sub-module cover_prio_enc #(WIDTH): lowest-set-bit index + any flag, combinational.
// TESTING
//  1. reset=0 for 3 cycles with valid=all-ones
//     -> evt_valid=0, hit_count=0, all_covered=0, no state retained after release.
//  2. COVER_INDEX=100; valid[3]=1 one cycle at edge t, evt_ready=1
//     -> evt_valid at edge t+1 with evt_index=103, hit_count=1; valid[3] again -> no event.
//  3. valid=all-ones one cycle, evt_ready=1
//     -> 65 events 100..164 ascending on consecutive cycles, hit_count=65, all_covered=1.
//  4. bits 0 and 7 pending, evt_ready=0 for 5 cycles
//     -> evt_index holds 100; evt_ready=1 -> 100 then 107, then evt_valid=0.
//  5. clr=1 with evt_valid=1, pending bit 9, valid[2]=1 same edge
//     -> next cycle evt_valid=0, hit_count=0, rd_hit(2)=0, no later events.
//  6. after bit 10 hit: rd_addr=10 -> rd_hit=1 next cycle; rd_addr=11 -> 0; rd_addr=70 -> 0.

Source files
------------

// File: rtl/cover_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cover_pkg
// Purpose  : Shared types for the toggle-cover collector (index type, FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package cover_pkg;

    localparam int unsigned COVER_TOTAL = 8744;

    typedef logic [63:0] cover_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cover_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : cover_prio_enc
// Purpose  : Combinational lowest-set-bit encoder with an any-bit-set flag.
// Revision : 1.0 - initial release
// ============================================================================
module cover_prio_enc #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module   : cover_toggle_collector
// Purpose  : Sticky first-hit bitmap for a toggle-cover group; streams each
//            newly covered point once as a global index over ready/valid.
// Revision : 1.0 - initial release
// ============================================================================
module cover_toggle_collector #(
    parameter int unsigned WIDTH       = 65,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = cover_pkg::COVER_TOTAL
) (
    input  logic                       gbl_clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       clr,
    output logic                       evt_valid,
    output logic [63:0]                evt_index,
    input  logic                       evt_ready,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic                       all_covered,
    input  logic [$clog2(WIDTH)-1:0]   rd_addr,
    output logic                       rd_hit
);

    import cover_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    if (64'(COVER_INDEX) + 64'(WIDTH) > 64'(COVER_TOTAL)) begin : g_range_check
        $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] hit_q, hit_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CW-1:0]    hit_count_q, hit_count_d;
    logic             rd_hit_q;
    logic             evt_valid_q;
    cover_idx_t       evt_index_q;
    state_t           state_q;

    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] taken;
    logic [CW-1:0]    new_count;
    logic             load;
    logic [IW-1:0]    enc_idx;
    logic             enc_any;
    cover_idx_t       next_index;

    cover_prio_enc #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_prio_enc (
        .vec_i (pending_q),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // The output register refills whenever it is empty or its event is being accepted.
    always_comb begin
        new_hits   = valid & ~hit_q;
        load       = enc_any && ((state_q == EMPTY) || evt_ready);
        taken      = load ? (ONE_HOT0 << enc_idx) : '0;
        next_index = cover_idx_t'(COVER_INDEX) + cover_idx_t'(enc_idx);
        new_count  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_count = new_count + CW'(new_hits[i]);
        end
        hit_d       = hit_q | valid;
        pending_d   = (pending_q & ~taken) | new_hits;
        hit_count_d = hit_count_q + new_count;
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            hit_q       <= '0;
            pending_q   <= '0;
            hit_count_q <= '0;
            rd_hit_q    <= 1'b0;
        end else begin
            rd_hit_q <= (32'(rd_addr) < WIDTH) ? hit_q[rd_addr] : 1'b0;
            if (clr) begin
                hit_q       <= '0;
                pending_q   <= '0;
                hit_count_q <= '0;
            end else begin
                hit_q       <= hit_d;
                pending_q   <= pending_d;
                hit_count_q <= hit_count_d;
            end
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            evt_valid_q <= 1'b0;
            evt_index_q <= '0;
        end else if (clr) begin
            state_q     <= EMPTY;
            evt_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        evt_index_q <= next_index;
                        evt_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (evt_ready) begin
                        if (load) begin
                            evt_index_q <= next_index;
                        end else begin
                            evt_valid_q <= 1'b0;
                            state_q     <= EMPTY;
                        end
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid   = evt_valid_q;
    assign evt_index   = evt_index_q;
    assign hit_count   = hit_count_q;
    assign all_covered = (hit_count_q == CW'(WIDTH));
    assign rd_hit      = rd_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cover_toggle_collector
// Purpose  : Scoreboard bench for cover_toggle_collector (WIDTH=65, COVER_INDEX=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cover_toggle_collector;

    localparam int unsigned WIDTH = 65;
    localparam int unsigned CIDX  = 100;
    localparam int unsigned CW    = $clog2(WIDTH + 1);
    localparam int unsigned AW    = $clog2(WIDTH);

    logic             gbl_clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] valid;
    logic             clr;
    logic             evt_valid;
    logic [63:0]      evt_index;
    logic             evt_ready;
    logic [CW-1:0]    hit_count;
    logic             all_covered;
    logic [AW-1:0]    rd_addr;
    logic             rd_hit;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_idx;

    cover_toggle_collector #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (CIDX),
        .COVER_TOTAL (8744)
    ) dut (
        .gbl_clk     (gbl_clk),
        .reset       (reset),
        .valid       (valid),
        .clr         (clr),
        .evt_valid   (evt_valid),
        .evt_index   (evt_index),
        .evt_ready   (evt_ready),
        .hit_count   (hit_count),
        .all_covered (all_covered),
        .rd_addr     (rd_addr),
        .rd_hit      (rd_hit)
    );

    always #5 gbl_clk = ~gbl_clk;

    // Every accepted event is matched against the next expected index.
    always @(negedge gbl_clk) begin
        if (reset === 1'b1 && clr === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL evt_stream: got unexpected event index %0d, expected none", evt_index);
            end else begin
                exp_idx = exp_q.pop_front();
                if (evt_index !== exp_idx) begin
                    n_errors++;
                    $display("FAIL evt_stream: got index %0d, expected %0d", evt_index, exp_idx);
                end
            end
        end
    end

    task automatic step();
        @(posedge gbl_clk);
        #1;
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        valid     = '1;
        clr       = 1'b0;
        evt_ready = 1'b1;
        rd_addr   = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b0 || hit_count !== '0 || all_covered !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_hold: got vld=%b cnt=%0d all=%b, expected 0/0/0",
                         evt_valid, hit_count, all_covered);
            end
        end
        reset = 1'b1;
        valid = '0;
        step();
        n_checks++;
        if (evt_valid !== 1'b0 || hit_count !== '0 || rd_hit !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got vld=%b cnt=%0d rd_hit=%b, expected 0/0/0",
                     evt_valid, hit_count, rd_hit);
        end
    endtask

    task automatic test_single_hit();
        evt_ready = 1'b1;
        valid     = '0;
        valid[3]  = 1'b1;
        exp_q.push_back(64'(CIDX + 3));
        step();
        valid = '0;
        n_checks++;
        if (evt_valid !== 1'b0 || hit_count !== CW'(1)) begin
            n_errors++;
            $display("FAIL single_latency: got vld=%b cnt=%0d, expected 0/1", evt_valid, hit_count);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_index !== 64'(CIDX + 3)) begin
            n_errors++;
            $display("FAIL single_event: got vld=%b idx=%0d, expected 1/%0d",
                     evt_valid, evt_index, CIDX + 3);
        end
        step();
        valid[3] = 1'b1;
        step();
        valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b0 || hit_count !== CW'(1)) begin
                n_errors++;
                $display("FAIL single_repeat: got vld=%b cnt=%0d, expected 0/1", evt_valid, hit_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_pulse();
        evt_ready = 1'b1;
        valid     = '1;
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(64'(CIDX + i));
        step();
        valid = '0;
        n_checks++;
        if (hit_count !== CW'(WIDTH) || all_covered !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_count: got cnt=%0d all=%b, expected %0d/1", hit_count, all_covered, WIDTH);
        end
        for (int i = 0; i < WIDTH; i++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b1 || evt_index !== 64'(CIDX + i)) begin
                n_errors++;
                $display("FAIL b2b_seq[%0d]: got vld=%b idx=%0d, expected 1/%0d",
                         i, evt_valid, evt_index, CIDX + i);
            end
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0 || all_covered !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_drain: got vld=%b all=%b, expected 0/1", evt_valid, all_covered);
        end
    endtask

    task automatic test_hold();
        clear_pulse();
        evt_ready = 1'b0;
        valid     = '0;
        valid[0]  = 1'b1;
        valid[7]  = 1'b1;
        exp_q.push_back(64'(CIDX + 0));
        exp_q.push_back(64'(CIDX + 7));
        step();
        valid = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b1 || evt_index !== 64'(CIDX)) begin
                n_errors++;
                $display("FAIL hold_stable: got vld=%b idx=%0d, expected 1/%0d", evt_valid, evt_index, CIDX);
            end
        end
        evt_ready = 1'b1;
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_index !== 64'(CIDX + 7)) begin
            n_errors++;
            $display("FAIL hold_second: got vld=%b idx=%0d, expected 1/%0d", evt_valid, evt_index, CIDX + 7);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_drain: got vld=%b, expected 0", evt_valid);
        end
    endtask

    task automatic test_clear();
        clear_pulse();
        evt_ready = 1'b0;
        valid     = '0;
        valid[0]  = 1'b1;
        valid[9]  = 1'b1;
        step();
        valid = '0;
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_index !== 64'(CIDX)) begin
            n_errors++;
            $display("FAIL clr_setup: got vld=%b idx=%0d, expected 1/%0d", evt_valid, evt_index, CIDX);
        end
        clr      = 1'b1;
        valid[2] = 1'b1;
        step();
        clr       = 1'b0;
        valid     = '0;
        rd_addr   = AW'(2);
        evt_ready = 1'b1;
        n_checks++;
        if (evt_valid !== 1'b0 || hit_count !== '0) begin
            n_errors++;
            $display("FAIL clr_state: got vld=%b cnt=%0d, expected 0/0", evt_valid, hit_count);
        end
        step();
        n_checks++;
        if (rd_hit !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_rd_hit2: got %b, expected 0", rd_hit);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b0 || hit_count !== '0) begin
                n_errors++;
                $display("FAIL clr_quiet: got vld=%b cnt=%0d, expected 0/0", evt_valid, hit_count);
            end
        end
    endtask

    task automatic test_rd_hit();
        evt_ready = 1'b1;
        valid     = '0;
        valid[10] = 1'b1;
        exp_q.push_back(64'(CIDX + 10));
        step();
        valid   = '0;
        rd_addr = AW'(10);
        step();
        n_checks++;
        if (rd_hit !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_hit10: got %b, expected 1", rd_hit);
        end
        rd_addr = AW'(11);
        step();
        n_checks++;
        if (rd_hit !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_hit11: got %b, expected 0", rd_hit);
        end
        rd_addr = AW'(70);
        step();
        n_checks++;
        if (rd_hit !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_hit70: got %b, expected 0", rd_hit);
        end
        step();
        n_checks++;
        if (hit_count !== CW'(1) || evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_final: got cnt=%0d vld=%b, expected 1/0", hit_count, evt_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_back_to_back();
        test_hold();
        test_clear();
        test_rd_hit();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d events outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
